instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, word-aligned address loaded into pc on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  leave STOPPED and begin fetching at current pc.
REQ-005 SHALL have port: halt  input  1  stop request from control path on invalid instruction.
REQ-006 SHALL have port: program_counter_inc  input  1  control path has consumed the presented instruction.
REQ-007 SHALL have port: jump_valid  input  1  redirect next fetch to jump_target; qualifies program_counter_inc.
REQ-008 SHALL have port: jump_target  input  32  redirect address; bits [1:0] forced to 0 when loaded.
REQ-009 SHALL have port: mem_req  output  1  read request to instruction memory.
REQ-010 SHALL have port: mem_addr  output  32  read address; equals pc.
REQ-011 SHALL have port: mem_ready  input  1  one-cycle strobe; mem_rdata valid this cycle.
REQ-012 SHALL have port: mem_rdata  input  32  instruction word returned by memory.
REQ-013 SHALL have port: instruction  output  32  registered instruction word presented to control path.
REQ-014 SHALL have port: instruction_valid  output  1  instruction holds a fetched, unconsumed word.
REQ-015 SHALL have port: pc  output  32  address of the presented or in-flight instruction.
REQ-016 SHALL have port: halted  output  1  high exactly when state is STOPPED.
REQ-017 SHALL have port: fetch_count  output  16  number of accepted memory responses, wraps mod 2^16.

Function
REQ-018 SHALL implement three states: STOPPED, FETCH, ISSUE.
REQ-019 SHALL, in STOPPED, drive mem_req=0 and instruction_valid=0, and go to FETCH on the cycle after start=1 with pc unchanged.
REQ-020 SHALL, in FETCH, drive mem_req=1 and mem_addr=pc, holding both stable until mem_ready; memory latency is unbounded.
REQ-021 SHALL, in FETCH with mem_ready=1, register mem_rdata into instruction, set instruction_valid=1, increment fetch_count, and enter ISSUE next cycle (minimum one cycle request-to-valid).
REQ-022 SHALL, in ISSUE, hold instruction and instruction_valid=1 with mem_req=0 until program_counter_inc=1.
REQ-023 SHALL, in ISSUE with program_counter_inc=1 and jump_valid=0, load pc<=pc+4 (wrapping mod 2^32), clear instruction_valid, and enter FETCH.
REQ-024 SHALL, in ISSUE with program_counter_inc=1 and jump_valid=1, load pc<={jump_target[31:2],2'b00} instead of pc+4.
REQ-025 SHALL ignore program_counter_inc and jump_valid outside ISSUE, mem_ready outside FETCH, and start outside STOPPED.
REQ-026 SHALL, on halt=1 in any state, enter STOPPED next cycle with instruction_valid=0, mem_req=0, pc retained; instruction register retains its value.
REQ-027 SHALL give halt priority over mem_ready, program_counter_inc and start in the same cycle; a response arriving with halt is discarded and fetch_count is not incremented.
REQ-028 SHALL restart fetching at the retained pc on start after halt.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, set state=STOPPED, pc=RESET_PC, instruction=0, instruction_valid=0, mem_req=0, fetch_count=0, halted=1.
REQ-030 SHALL give reset priority over all other inputs, including mid-fetch; outstanding responses are then ignored until a new FETCH.

Verification
REQ-031 SHALL pass: reset, start, mem_ready after 3 cycles with 32'hDEAD_BEEF -> mem_addr=0 held 3 cycles, then instruction=32'hDEAD_BEEF, valid=1, fetch_count=1.
REQ-032 SHALL pass: in ISSUE at pc=8, program_counter_inc -> next cycle valid=0, mem_req=1, mem_addr=12.
REQ-033 SHALL pass: in ISSUE, program_counter_inc with jump_valid and jump_target=32'h0000_0107 -> mem_addr=32'h0000_0104.
REQ-034 SHALL pass: halt and mem_ready same cycle at pc=16 -> halted=1, valid=0, fetch_count unchanged; start -> mem_addr=16.
REQ-035 SHALL pass: pc=32'hFFFF_FFFC, program_counter_inc -> mem_addr=32'h0000_0000.
REQ-036 SHALL pass: reset asserted during FETCH -> all outputs at reset values next cycle; late mem_ready ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one instruction word at a time from
// instruction memory, holds it for the control path until consumed, and then
// advances the program counter sequentially or to a jump target.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt,
   input  logic        program_counter_inc,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instruction,
   output logic        instruction_valid,
   output logic [31:0] pc,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      FETCH   = 2'd1,
      ISSUE   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [15:0] fetch_count_q, fetch_count_d;

   // Next-state and datapath updates; halt overrides every other request.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      fetch_count_d = fetch_count_q;

      if (halt) begin
         // A response coinciding with halt is dropped; pc and instruction stay.
         state_d = STOPPED;
      end else begin
         unique case (state_q)
            STOPPED: begin
               if (start) state_d = FETCH;
            end
            FETCH: begin
               if (mem_ready) begin
                  instr_d       = mem_rdata;
                  fetch_count_d = fetch_count_q + 16'd1;
                  state_d       = ISSUE;
               end
            end
            ISSUE: begin
               if (program_counter_inc) begin
                  // Jump targets are forced word-aligned; pc+4 wraps naturally.
                  pc_d    = jump_valid ? {jump_target[31:2], 2'b00} : pc_q + 32'd4;
                  state_d = FETCH;
               end
            end
            default: state_d = STOPPED;
         endcase
      end
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from values sampled before the edge.
      if (reset) begin
         state_q       <= STOPPED;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0000_0000;
         fetch_count_q <= 16'h0000;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Outputs decode directly from registered state, so they are glitch-free
   // and change only on clock edges.
   always_comb begin
      mem_req           = (state_q == FETCH);
      instruction_valid = (state_q == ISSUE);
      halted            = (state_q == STOPPED);
      mem_addr          = pc_q;
      pc                = pc_q;
      instruction       = instr_q;
      fetch_count       = fetch_count_q;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the fetch
// protocol kept here.
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, start, halt, program_counter_inc, jump_valid, mem_ready;
   logic [31:0] jump_target, mem_rdata;
   logic        mem_req, instruction_valid, halted;
   logic [31:0] mem_addr, instruction, pc;
   logic [15:0] fetch_count;

   int errors = 0;
   int checks = 0;

   // Behavioural model: the unit is either halted, waiting on memory, or
   // holding an unconsumed instruction.
   logic        m_halted;
   logic        m_have;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   int unsigned m_count;

   instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .halt                (halt),
      .program_counter_inc (program_counter_inc),
      .jump_valid          (jump_valid),
      .jump_target         (jump_target),
      .mem_req             (mem_req),
      .mem_addr            (mem_addr),
      .mem_ready           (mem_ready),
      .mem_rdata           (mem_rdata),
      .instruction         (instruction),
      .instruction_valid   (instruction_valid),
      .pc                  (pc),
      .halted              (halted),
      .fetch_count         (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b0; start = 1'b0; halt = 1'b0; program_counter_inc = 1'b0;
      jump_valid = 1'b0; jump_target = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
   endtask

   // Advance the model with the inputs currently applied, clock the DUT, then
   // compare every output a little after the edge.
   task automatic tick(input string tag);
      if (reset) begin
         m_halted = 1'b1; m_have = 1'b0; m_pc = RESET_PC; m_instr = 32'h0; m_count = 0;
      end else if (halt) begin
         m_halted = 1'b1; m_have = 1'b0;
      end else if (m_halted) begin
         if (start) m_halted = 1'b0;
      end else if (!m_have) begin
         if (mem_ready) begin
            m_instr = mem_rdata; m_have = 1'b1; m_count = (m_count + 1) % 65536;
         end
      end else if (program_counter_inc) begin
         m_pc   = jump_valid ? (jump_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
         m_have = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, ".halted"},  32'(halted),            32'(m_halted));
      check({tag, ".valid"},   32'(instruction_valid), 32'(m_have));
      check({tag, ".mem_req"}, 32'(mem_req),           32'(!m_halted && !m_have));
      check({tag, ".addr"},    mem_addr,               m_pc);
      check({tag, ".pc"},      pc,                     m_pc);
      check({tag, ".instr"},   instruction,            m_instr);
      check({tag, ".count"},   32'(fetch_count),       m_count);
   endtask

   initial begin
      m_halted = 1'b1; m_have = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_count = 0;
      idle_inputs();

      // Reset state.
      reset = 1'b1;
      tick("reset");
      idle_inputs();
      tick("reset_idle");

      // Start, memory answers on the third cycle of the request.
      start = 1'b1;
      tick("start");
      idle_inputs();
      tick("wait1");
      tick("wait2");
      check("hold_addr", mem_addr, 32'h0);
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick("resp_deadbeef");
      idle_inputs();
      check("deadbeef_instr", instruction, 32'hDEAD_BEEF);
      check("deadbeef_count", 32'(fetch_count), 32'd1);
      tick("issue_hold");

      // Sequential advance through pc=4 and pc=8 to pc=12.
      program_counter_inc = 1'b1; tick("inc_to_4"); idle_inputs();
      mem_ready = 1'b1; mem_rdata = 32'h1111_0004; tick("resp_4"); idle_inputs();
      program_counter_inc = 1'b1; tick("inc_to_8"); idle_inputs();
      mem_ready = 1'b1; mem_rdata = 32'h1111_0008; tick("resp_8"); idle_inputs();
      program_counter_inc = 1'b1; tick("inc_to_12"); idle_inputs();
      check("pc12_addr", mem_addr, 32'd12);

      // Jump with a misaligned target.
      mem_ready = 1'b1; mem_rdata = 32'h1111_000C; tick("resp_12"); idle_inputs();
      program_counter_inc = 1'b1; jump_valid = 1'b1; jump_target = 32'h0000_0107;
      tick("jump_107"); idle_inputs();
      check("jump_addr", mem_addr, 32'h0000_0104);

      // Jump to 16, then halt colliding with a response.
      mem_ready = 1'b1; mem_rdata = 32'h2222_0104; tick("resp_104"); idle_inputs();
      program_counter_inc = 1'b1; jump_valid = 1'b1; jump_target = 32'h0000_0010;
      tick("jump_16"); idle_inputs();
      halt = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
      tick("halt_vs_ready"); idle_inputs();
      program_counter_inc = 1'b1; mem_ready = 1'b1; tick("stopped_ignores"); idle_inputs();
      start = 1'b1; tick("restart"); idle_inputs();
      check("restart_addr", mem_addr, 32'd16);

      // Address wrap at the top of memory.
      mem_ready = 1'b1; mem_rdata = 32'h3333_0010; tick("resp_16"); idle_inputs();
      program_counter_inc = 1'b1; jump_valid = 1'b1; jump_target = 32'hFFFF_FFFF;
      tick("jump_top"); idle_inputs();
      mem_ready = 1'b1; mem_rdata = 32'h4444_FFFC; tick("resp_top"); idle_inputs();
      program_counter_inc = 1'b1; tick("wrap"); idle_inputs();
      check("wrap_addr", mem_addr, 32'h0);

      // Reset in the middle of a fetch, then a late response.
      tick("fetch_wait");
      reset = 1'b1; tick("reset_mid_fetch"); idle_inputs();
      mem_ready = 1'b1; mem_rdata = 32'h5555_5555; tick("late_ready"); idle_inputs();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         reset               = ($urandom_range(0, 63) == 0);
         halt                = ($urandom_range(0, 15) == 0);
         start               = ($urandom_range(0, 3) == 0);
         program_counter_inc = ($urandom_range(0, 2) == 0);
         jump_valid          = ($urandom_range(0, 2) == 0);
         jump_target         = $urandom;
         mem_ready           = ($urandom_range(0, 2) == 0);
         mem_rdata           = $urandom;
         tick("random");
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
